dma_rd_streamer: RTL

Read-side streamer that serves the DMA control FSM's read-stream handshake. On a valid read descriptor it splits the transfer into AXI4 INCR read-burst requests and issues them to the AXI interface. It tracks outstanding bursts and their in-order completions, then returns a done indication and, on failure, one error record. It sits between the DMA FSM (valid/done/err) and the AXI master I/F read-address path.

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_rd_streamer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types: error-record layout and source codes reported by the streamers.
package dma_pkg;

    typedef enum logic [1:0] {
        ErrSrcNone     = 2'd0,
        ErrSrcRdStream = 2'd1,
        ErrSrcWrStream = 2'd2,
        ErrSrcDesc     = 2'd3
    } dma_err_src_e;

    typedef struct packed {
        logic         valid;
        dma_err_src_e src;
        logic [31:0]  addr;
    } s_dma_error_t;

endpackage

// File: rtl/dma_rd_streamer.sv
// Read-side DMA streamer: splits a read descriptor into AXI4 INCR burst requests,
// tracks in-order completions and reports done plus at most one error per descriptor.
module dma_rd_streamer
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 32,
    parameter int unsigned DATA_BYTES      = 8,
    parameter int unsigned MAX_BEATS       = 256,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dma_stream_valid_i,
    input  logic                  dma_clear_i,
    input  logic [ADDR_WIDTH-1:0] desc_src_addr_i,
    input  logic [LEN_WIDTH-1:0]  desc_num_bytes_i,
    output logic                  dma_stream_done_o,
    output s_dma_error_t          dma_stream_err_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [7:0]            req_len_o,
    output logic [2:0]            req_size_o,
    input  logic                  rsp_valid_i,
    input  logic                  rsp_err_i
);

    localparam int unsigned OffW  = $clog2(DATA_BYTES);
    localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned Depth = 1 << PtrW;
    localparam logic [CntW-1:0] MaxOut   = CntW'(MAX_OUTSTANDING);
    localparam logic [8:0]      MaxBeats = 9'(MAX_BEATS);

    typedef enum logic [2:0] {StIdle, StCheck, StReq, StWait, StDone} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   bytes_q, bytes_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH-1:0]  fifo_q [Depth];
    logic                   lock_q, lock_d;
    logic                   done_q, done_d;
    s_dma_error_t           err_q, err_d;

    logic [12:0]            page_beats;
    logic [LEN_WIDTH-1:0]   left_beats;
    logic [8:0]             beats;
    logic [ADDR_WIDTH-1:0]  burst_addr_inc;
    logic [LEN_WIDTH-1:0]   burst_byte_cnt;
    logic                   fire, pop, rsp_fail;

    // Burst size is the tightest of remaining bytes, MAX_BEATS and room left in the 4 KB page.
    always_comb begin
        page_beats = (13'h1000 - {1'b0, addr_q[11:0]}) >> OffW;
        left_beats = bytes_q >> OffW;
        beats      = MaxBeats;
        if (left_beats < LEN_WIDTH'(MAX_BEATS)) beats = left_beats[8:0];
        if (page_beats < {4'd0, beats}) beats = page_beats[8:0];
        burst_addr_inc = ADDR_WIDTH'(beats) << OffW;
        burst_byte_cnt = LEN_WIDTH'(beats) << OffW;
    end

    assign req_valid_o = (state_q == StReq) && (cnt_q != MaxOut);
    assign req_addr_o  = addr_q;
    assign req_len_o   = 8'(beats - 9'd1);
    assign req_size_o  = 3'(OffW);

    assign fire     = req_valid_o && req_ready_i;
    assign pop      = rsp_valid_i && (cnt_q != '0);
    assign rsp_fail = pop && rsp_err_i && !lock_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bytes_d = bytes_q;
        lock_d  = lock_q;
        err_d   = '0;
        cnt_d   = cnt_q + CntW'(fire) - CntW'(pop);

        if (fire) begin
            addr_d  = addr_q + burst_addr_inc;
            bytes_d = bytes_q - burst_byte_cnt;
        end

        // FIFO head is the oldest outstanding burst, i.e. the one that just failed.
        if (rsp_fail) begin
            lock_d     = 1'b1;
            err_d.valid = 1'b1;
            err_d.src  = ErrSrcRdStream;
            err_d.addr = 32'(fifo_q[rd_ptr_q]);
        end

        unique case (state_q)
            StIdle: begin
                if (dma_stream_valid_i) begin
                    addr_d  = desc_src_addr_i;
                    bytes_d = desc_num_bytes_i;
                    lock_d  = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (bytes_q == '0) begin
                    state_d = StDone;
                end else if ((addr_q[OffW-1:0] != '0) || (bytes_q[OffW-1:0] != '0)) begin
                    err_d.valid = 1'b1;
                    err_d.src  = ErrSrcRdStream;
                    err_d.addr = 32'(addr_q);
                    state_d    = StDone;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (rsp_fail || (fire && (bytes_d == '0))) state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) state_d = StDone;
            end
            StDone: begin
                if (!dma_stream_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        done_d = (state_d == StDone) && (state_q != StDone);

        if (dma_clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            lock_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            bytes_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lock_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (dma_clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (fire) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire && !dma_clear_i) fifo_q[wr_ptr_q] <= addr_q;
    end

    assign dma_stream_done_o = done_q;
    assign dma_stream_err_o  = err_q;

endmodule
